// File: rtl/frame_ram_writer.sv
// Write side of the grayscale frame RAM: stores a raster pixel stream (or a constant fill) one pixel per 32-bit word.
// Optional constant-fill (CLEAR) support is enabled by defining FRAME_RAM_WRITER_CLEAR_EN.
module frame_ram_writer #(
    parameter int          IMG_W     = 256,
    parameter int          IMG_H     = 256,
    parameter int          ADDR_W    = 17,
    parameter logic [7:0]  CLEAR_VAL = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic [7:0]        pix_data,
    input  logic              pix_valid,
    input  logic              pix_last,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] wraddress,
    output logic [31:0]       data,
    output logic              wren,
    output logic              busy,
    output logic              frame_done,
    output logic              err_len
);

    localparam int                N_PIX    = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PIX - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   cnt_r;
    logic [ADDR_W-1:0]   cnt_s;
    logic                wr_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [31:0]         data_s;
    logic                err_s;
    logic                xfer_s;

    logic                pix_ready_r;
    logic [ADDR_W-1:0]   wraddress_r;
    logic [31:0]         data_r;
    logic                wren_r;
    logic                busy_r;
    logic                frame_done_r;
    logic                err_len_r;

`ifndef FRAME_RAM_WRITER_CLEAR_EN
    logic                unused_clear_s;
    assign unused_clear_s = ^{clear, CLEAR_VAL};
`endif

    // Next-state, counter and write-port decode; the write registered here appears on the RAM port next cycle.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        wr_s    = 1'b0;
        addr_s  = wraddress_r;
        data_s  = data_r;
        err_s   = err_len_r;
        xfer_s  = pix_valid & pix_ready_r;

        case (state_r)
            ST_IDLE: begin
`ifdef FRAME_RAM_WRITER_CLEAR_EN
                // The address-0 fill word is issued on the same edge that samples clear.
                if (clear) begin
                    wr_s   = 1'b1;
                    addr_s = ADDR_ZERO;
                    data_s = {24'h000000, CLEAR_VAL};
                    cnt_s  = ADDR_ONE;
                    if (LAST_IDX == ADDR_ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CLEAR;
                    end
                end else if (start) begin
                    state_s = ST_LOAD;
                    cnt_s   = ADDR_ZERO;
                    err_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
`else
                if (start) begin
                    state_s = ST_LOAD;
                    cnt_s   = ADDR_ZERO;
                    err_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
`endif
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    wr_s   = 1'b1;
                    addr_s = cnt_r;
                    data_s = {24'h000000, pix_data};
                    cnt_s  = cnt_r + ADDR_ONE;
                    if (cnt_r == LAST_IDX) begin
                        state_s = ST_DONE;
                        err_s   = err_len_r | ~pix_last;
                    end else if (pix_last) begin
                        state_s = ST_DONE;
                        err_s   = 1'b1;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
`ifdef FRAME_RAM_WRITER_CLEAR_EN
            ST_CLEAR: begin
                wr_s   = 1'b1;
                addr_s = cnt_r;
                data_s = {24'h000000, CLEAR_VAL};
                cnt_s  = cnt_r + ADDR_ONE;
                if (cnt_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
`endif
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; status outputs are decoded from the next state so they align with the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= ADDR_ZERO;
            pix_ready_r  <= 1'b0;
            wraddress_r  <= ADDR_ZERO;
            data_r       <= 32'h0000_0000;
            wren_r       <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            err_len_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            pix_ready_r  <= (state_s == ST_LOAD);
            wraddress_r  <= addr_s;
            data_r       <= data_s;
            wren_r       <= wr_s;
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= (state_s == ST_DONE);
            err_len_r    <= err_s;
        end
    end

    assign pix_ready  = pix_ready_r;
    assign wraddress  = wraddress_r;
    assign data       = data_r;
    assign wren       = wren_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign err_len    = err_len_r;

endmodule

// File: tb/tb_frame_ram_writer.sv
// Randomized scoreboard bench for frame_ram_writer with a 4x2 frame; follows FRAME_RAM_WRITER_CLEAR_EN if defined.
module tb_frame_ram_writer;

    localparam int N  = 8;
    localparam int AW = 17;
`ifdef FRAME_RAM_WRITER_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [7:0]    pix_data = 8'h00;
    logic          pix_valid = 1'b0;
    logic          pix_last = 1'b0;
    logic          pix_ready;
    logic [AW-1:0] wraddress;
    logic [31:0]   data;
    logic          wren;
    logic          busy;
    logic          frame_done;
    logic          err_len;

    typedef struct {
        int          addr;
        logic [31:0] wdata;
        bit          done;
        int          cyc;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   exp_err = 1'b0;

    frame_ram_writer #(
        .IMG_W(4), .IMG_H(2), .ADDR_W(AW), .CLEAR_VAL(8'hFF)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last),
        .pix_ready(pix_ready), .wraddress(wraddress), .data(data), .wren(wren),
        .busy(busy), .frame_done(frame_done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every RAM write must match the oldest expected write, including its cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wren === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", wraddress, data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(wraddress), mon_e.addr);
                    check("wr_data", data, mon_e.wdata);
                    check("wr_cycle", cyc, mon_e.cyc);
                    check("wr_frame_done", 32'(frame_done), 32'(mon_e.done));
                end
            end else begin
                check("wren_low", 32'(wren), 32'd0);
                check("frame_done_no_write", 32'(frame_done), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input bit e_err);
        check("busy_idle", 32'(busy), 32'd0);
        check("ready_idle", 32'(pix_ready), 32'd0);
        check("err_len", 32'(err_len), 32'(e_err));
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        pix_valid = 1'b0;
        pix_last = 1'b0;
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_wraddress", 32'(wraddress), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err_len", 32'(err_len), 32'd0);
        check("rst_queue", exp_q.size(), 32'd0);
    endtask

    // Issue start (optionally with clear); a clear runs to completion here.
    task automatic start_op(input bit use_clear, output bit loading);
        loading = !(use_clear && CLR_EN);
        start = 1'b1;
        clear = use_clear;
        if (!loading) begin
            for (int j = 0; j < N; j++) begin
                exp_q.push_back('{addr: j, wdata: 32'h0000_00FF, done: (j == N - 1), cyc: cyc + 1 + j});
            end
        end
        tick();
        start = 1'b0;
        clear = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("ready_after_start", 32'(pix_ready), 32'(loading));
        if (loading) begin
            exp_err = 1'b0;
            check("err_len_cleared", 32'(err_len), 32'd0);
        end else begin
            repeat (N - 1) tick();
            check("busy_clear_done", 32'(busy), 32'd1);
            tick();
            check_idle(exp_err);
        end
    endtask

    // Offer one frame; the model accepts every valid beat until N pixels or pix_last.
    task automatic load_frame(input int last_at, input int gap_mode, input bit fixed_data,
                              input int stop_after, input bit offer_extra);
        int k = 0;
        int iter = 0;
        bit ended = 1'b0;
        bit tog = 1'b1;
        bit v;
        while (!ended && k < stop_after) begin
            v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            pix_valid = v;
            pix_last = 1'b0;
            pix_data = 8'($urandom_range(0, 255));
            if (v) begin
                if (fixed_data) pix_data = 8'h10 + 8'(k);
                pix_last = (k == last_at);
                check("ready_in_load", 32'(pix_ready), 32'd1);
                exp_q.push_back('{addr: k, wdata: {24'h0, pix_data},
                                  done: (k == N - 1) || (k == last_at), cyc: cyc + 1});
                if (k == N - 1 || k == last_at) ended = 1'b1;
                k++;
            end
            tick();
            iter++;
            if (iter > 500) begin
                n_vec++;
                n_err++;
                $display("FAIL load_timeout: %0d pixels accepted, expected frame end", k);
                break;
            end
        end
        pix_valid = 1'b0;
        pix_last = 1'b0;
        if (ended) begin
            exp_err = (last_at != N - 1);
            if (offer_extra) begin
                pix_valid = 1'b1;
                pix_last = 1'b1;
                pix_data = 8'($urandom_range(0, 255));
            end
            check("ready_in_done", 32'(pix_ready), 32'd0);
            check("busy_in_done", 32'(busy), 32'd1);
            tick();
            pix_valid = 1'b0;
            pix_last = 1'b0;
            check_idle(exp_err);
        end
    endtask

    initial begin
        bit ld;
        int r;
        int last;
        do_reset();
        mon_en = 1'b1;

        start_op(1'b0, ld);
        load_frame(N - 1, 0, 1'b1, N, 1'b0);

        start_op(1'b0, ld);
        load_frame(N - 1, 1, 1'b0, N, 1'b0);

        start_op(1'b0, ld);
        load_frame(4, 0, 1'b0, N, 1'b0);
        start_op(1'b0, ld);
        load_frame(N - 1, 2, 1'b0, N, 1'b0);

        start_op(1'b0, ld);
        load_frame(N + 10, 0, 1'b0, N, 1'b1);

        start_op(1'b1, ld);
        if (ld) load_frame(N - 1, 0, 1'b0, N, 1'b0);

        start_op(1'b0, ld);
        load_frame(N - 1, 0, 1'b0, 3, 1'b0);
        do_reset();
        start_op(1'b0, ld);
        load_frame(N - 1, 0, 1'b1, N, 1'b0);

        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 2)) tick();
            start_op(($urandom_range(0, 3) == 0), ld);
            if (ld) begin
                r = $urandom_range(0, 2);
                last = (r == 0) ? N - 1 : (r == 1) ? $urandom_range(0, N - 2) : N + 5;
                load_frame(last, $urandom_range(0, 2), 1'b0, N, 1'($urandom_range(0, 1)));
            end
        end

        tick();
        check("final_queue", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
